axis_sample_capture: RTL and testbench
======================================

AXIS_SAMPLE_CAPTURE -- requirements
Module: axis_sample_capture

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sets the signed two's-complement sample width.
REQ-002 Parameter ADDR_WIDTH, default 10, sets buffer depth DEPTH = 2^ADDR_WIDTH samples.
REQ-003 aclk  in  1  clock; all logic is rising-edge.
REQ-004 resetn  in  1  reset; synchronous, active-low.
REQ-005 s_axis_tdata  in  DATA_WIDTH  signed sample.
REQ-006 s_axis_tlast  in  1  end-of-frame marker.
REQ-007 s_axis_tvalid  in  1  sample valid.
REQ-008 s_axis_tready  out  1  sink ready.
REQ-009 arm  in  1  single-cycle pulse that starts a capture.
REQ-010 trig_mode  in  2  trigger source: 0 immediate, 1 rising threshold, 2 after tlast, 3 reserved (behaves as 0).
REQ-011 trig_level  in  DATA_WIDTH  signed threshold for mode 1.
REQ-012 capture_len  in  ADDR_WIDTH+1  number of samples to store.
REQ-013 rd_addr  in  ADDR_WIDTH  buffer read address.
REQ-014 rd_data  out  DATA_WIDTH  buffer read data.
REQ-015 busy  out  1  high in ARMED or CAPTURE.
REQ-016 done  out  1  high in DONE.
REQ-017 sample_count  out  ADDR_WIDTH+1  number of samples stored in the current or last capture.

Function
REQ-018 A transfer SHALL occur on any cycle with s_axis_tvalid and s_axis_tready both high; no other cycle changes state because of input data.
REQ-019 s_axis_tready SHALL be registered, 0 during reset, and 1 on every cycle after reset; transfers outside CAPTURE are consumed and discarded.
REQ-020 The FSM SHALL have the states IDLE, ARMED, CAPTURE and DONE.
REQ-021 IDLE/DONE -> ARMED on arm: latch trig_mode, trig_level and effective length L, clear sample_count, deassert done.
REQ-022 L = DEPTH when capture_len is 0 or greater than DEPTH; otherwise L = capture_len.
REQ-023 arm SHALL be ignored in ARMED and CAPTURE.
REQ-024 Mode 0: the first transfer in ARMED SHALL be the trigger sample.
REQ-025 Mode 1: the trigger sample is a transfer with tdata >= trig_level (signed) whose previous accepted transfer was < trig_level.
REQ-026 Mode 1: the previous-sample register SHALL update on every transfer in any state; it is invalid after reset and after arm, so the first transfer after either cannot trigger.
REQ-027 Mode 2: the trigger sample is the first transfer after a transfer with tlast=1 accepted in ARMED.
REQ-028 Trigger handling: the trigger sample SHALL be written to address 0, and the FSM moves ARMED -> CAPTURE with sample_count=1.
REQ-029 If L=1, the trigger sample SHALL move the FSM directly from ARMED to DONE.
REQ-030 Each transfer in CAPTURE SHALL write to address sample_count and increment sample_count.
REQ-031 The transfer that makes sample_count equal L SHALL move the FSM CAPTURE -> DONE in the same edge.
REQ-032 Addresses SHALL never wrap; at most L writes occur per capture.
REQ-033 The buffer SHALL be a single simple-dual-port RAM with synchronous write and registered read; rd_data equals mem[rd_addr] one cycle after rd_addr is presented.
REQ-034 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-035 busy, done and sample_count SHALL be registered and update on the edge that changes state.
REQ-036 tlast SHALL have no effect outside mode-2 ARMED.

Reset
REQ-037 While resetn=0 the block SHALL hold: state IDLE, s_axis_tready 0, busy 0, done 0, sample_count 0, rd_data 0, previous-sample register invalid.
REQ-038 Buffer contents SHALL NOT be cleared by reset and are undefined after it.
REQ-039 Reset mid-capture SHALL abort the capture; the next capture requires a new arm.

Verification
REQ-040 Immediate capture: mode 0, capture_len 4, arm, then samples 10,11,12,13,14 -> mem[0..3]=10..13, done after the 4th transfer, sample_count 4, and 14 is discarded.
REQ-041 Threshold trigger: mode 1, trig_level 100, stream 50,99,100,200,30,150 with capture_len 3 -> stores 100,200,30; the later crossing at 150 is ignored.
REQ-042 tlast trigger with stalls: mode 2, tlast on the 3rd sample and tvalid toggling every cycle, capture_len 2 -> stores samples 4 and 5; no write occurs on cycles with tvalid low.
REQ-043 Length edge cases: capture_len 0 and capture_len DEPTH+5 each capture DEPTH samples with the last at address DEPTH-1 and no wrap; capture_len 1 goes from ARMED to DONE on a single transfer.
REQ-044 Reset abort: assert resetn=0 for one cycle after 5 of 8 samples in CAPTURE -> IDLE, busy 0, sample_count 0; arm during CAPTURE with no reset is ignored and the capture length is unchanged.
REQ-045 Readback: sweep rd_addr 0..L-1 after DONE -> rd_data matches the stored samples with 1-cycle latency.

Source files
------------

// File: rtl/axis_sample_capture.sv
// AXI-Stream triggered sample capture.
// Waits for a trigger (immediate, rising threshold crossing, or frame start
// after tlast), then stores up to L consecutive samples into a simple
// dual-port RAM that can be read back through rd_addr/rd_data.
module axis_sample_capture #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  arm,
    input  logic [1:0]            trig_mode,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic [ADDR_WIDTH:0]   capture_len,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   sample_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state, state_n;

    // Latched capture configuration
    logic [1:0]                   mode_q;
    logic signed [DATA_WIDTH-1:0] level_q;
    logic [ADDR_WIDTH:0]          len_q;

    // Trigger history
    logic signed [DATA_WIDTH-1:0] prev_q;
    logic                         prev_vld;
    logic                         last_seen;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  xfer;
    logic                  crossing;
    logic                  trig;
    logic [ADDR_WIDTH:0]   eff_len;
    logic [ADDR_WIDTH:0]   count_n;
    logic                  arm_take;
    logic                  we;
    logic [ADDR_WIDTH-1:0] wr_addr;

    assign xfer     = s_axis_tvalid & s_axis_tready;
    assign crossing = prev_vld && (prev_q < level_q) &&
                      ($signed(s_axis_tdata) >= level_q);
    assign eff_len  = ((capture_len == '0) || (capture_len > DEPTH_L)) ? DEPTH_L : capture_len;

    // Trigger qualifier for the latched mode; reserved mode acts as immediate
    always_comb begin
        trig = 1'b1;
        case (mode_q)
            2'd1:    trig = crossing;
            2'd2:    trig = last_seen;
            default: trig = 1'b1;
        endcase
    end

    // Next-state, write strobe and next sample count
    always_comb begin
        state_n  = state;
        count_n  = sample_count;
        arm_take = 1'b0;
        we       = 1'b0;
        wr_addr  = '0;
        case (state)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_n  = S_ARMED;
                    count_n  = '0;
                    arm_take = 1'b1;
                end
            end
            S_ARMED: begin
                if (xfer && trig) begin
                    we      = 1'b1;
                    wr_addr = '0;
                    count_n = ONE_L;
                    state_n = (len_q == ONE_L) ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (xfer) begin
                    we      = 1'b1;
                    wr_addr = sample_count[ADDR_WIDTH-1:0];
                    count_n = sample_count + ONE_L;
                    if ((sample_count + ONE_L) == len_q)
                        state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register and registered status outputs
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            s_axis_tready <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            sample_count  <= '0;
        end else begin
            state         <= state_n;
            s_axis_tready <= 1'b1;
            busy          <= (state_n == S_ARMED) || (state_n == S_CAPTURE);
            done          <= (state_n == S_DONE);
            sample_count  <= count_n;
        end
    end

    // Capture configuration, sampled once per arm
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            mode_q  <= '0;
            level_q <= '0;
            len_q   <= DEPTH_L;
        end else if (arm_take) begin
            mode_q  <= trig_mode;
            level_q <= $signed(trig_level);
            len_q   <= eff_len;
        end
    end

    // Previous accepted sample (any state) and tlast-seen flag for mode 2
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            prev_q    <= '0;
            prev_vld  <= 1'b0;
            last_seen <= 1'b0;
        end else if (arm_take) begin
            prev_vld  <= 1'b0;
            last_seen <= 1'b0;
        end else begin
            if (xfer) begin
                prev_q   <= $signed(s_axis_tdata);
                prev_vld <= 1'b1;
            end
            if (state == S_ARMED && mode_q == 2'd2 && xfer && s_axis_tlast)
                last_seen <= 1'b1;
        end
    end

    // Buffer write port; no writes on a reset edge so an aborted capture stops cleanly
    always_ff @(posedge aclk) begin
        if (we && resetn)
            mem[wr_addr] <= s_axis_tdata;
    end

    // Registered read port; same-address collisions return the pre-write data
    always_ff @(posedge aclk) begin
        if (!resetn)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_axis_sample_capture.sv
// Directed bench for axis_sample_capture with a readback scoreboard.
module tb_axis_sample_capture;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic          aclk = 1'b0;
    logic          resetn;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          arm;
    logic [1:0]    trig_mode;
    logic [DW-1:0] trig_level;
    logic [AW:0]   capture_len;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   sample_count;

    typedef struct {
        int            addr;
        logic [DW-1:0] exp;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      checks = 0;
    int      errors = 0;
    logic    rd_en  = 1'b0;
    logic    rd_seen = 1'b0;
    int      rd_addr_seen = 0;

    axis_sample_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .aclk          (aclk),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .arm           (arm),
        .trig_mode     (trig_mode),
        .trig_level    (trig_level),
        .capture_len   (capture_len),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .sample_count  (sample_count)
    );

    always #5 aclk = ~aclk;

    // Track which read requests the DUT registered on each edge
    always @(posedge aclk) begin
        rd_seen      <= rd_en;
        rd_addr_seen <= int'(rd_addr);
    end

    // Monitor: pop the oldest expected read and compare against rd_data
    always @(negedge aclk) begin
        if (rd_seen) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data addr %0d: got %0d, no expected entry queued", rd_addr_seen, $signed(rd_data));
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                if (rd_data !== e.exp || e.addr != rd_addr_seen) begin
                    errors++;
                    $display("FAIL rd_data addr %0d (exp addr %0d): got %0d, want %0d",
                             rd_addr_seen, e.addr, $signed(rd_data), $signed(e.exp));
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name, input int b, input int d, input int cnt);
        chk({name, " busy"}, int'(busy), b);
        chk({name, " done"}, int'(done), d);
        chk({name, " count"}, int'(sample_count), cnt);
    endtask

    task automatic send(input int d, input bit last);
        s_axis_tdata  = d[DW-1:0];
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic do_arm(input int mode, input int level, input int len);
        trig_mode   = mode[1:0];
        trig_level  = level[DW-1:0];
        capture_len = len[AW:0];
        arm         = 1'b1;
        tick();
        arm         = 1'b0;
    endtask

    task automatic rd(input int a, input int exp);
        rd_exp_t e;
        e.addr  = a;
        e.exp   = exp[DW-1:0];
        rd_q.push_back(e);
        rd_addr = a[AW-1:0];
        rd_en   = 1'b1;
        tick();
        rd_en   = 1'b0;
    endtask

    initial begin
        resetn        = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        arm           = 1'b0;
        trig_mode     = '0;
        trig_level    = '0;
        capture_len   = '0;
        rd_addr       = '0;
        repeat (3) tick();

        // Reset state
        chk("reset tready", int'(s_axis_tready), 0);
        chk("reset rd_data", int'(rd_data), 0);
        chk_status("reset", 0, 0, 0);
        resetn = 1'b1;
        tick();
        chk("tready after reset", int'(s_axis_tready), 1);

        // capture_len 0 -> DEPTH samples, filling the whole buffer
        do_arm(0, 0, 0);
        chk_status("len0 armed", 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            send(1000 + i, 1'b0);
            if (i == DEPTH - 2) chk_status("len0 one short", 1, 0, DEPTH - 1);
        end
        chk_status("len0 end", 0, 1, DEPTH);
        send(999, 1'b0);
        chk_status("len0 extra", 0, 1, DEPTH);
        for (int i = 0; i < DEPTH; i++) rd(i, 1000 + i);

        // capture_len DEPTH+5 clamps to DEPTH, no wrap onto address 0
        do_arm(0, 0, DEPTH + 5);
        for (int i = 0; i <= DEPTH; i++) send(2000 + i, 1'b0);
        chk_status("lenbig end", 0, 1, DEPTH);
        for (int i = 0; i < DEPTH; i++) rd(i, 2000 + i);

        // capture_len 1 in reserved mode 3 (immediate): ARMED -> DONE
        do_arm(3, 0, 1);
        chk_status("len1 armed", 1, 0, 0);
        send(77, 1'b0);
        chk_status("len1 end", 0, 1, 1);
        rd(0, 77);

        // Immediate capture of 4; tlast ignored in mode 0; 14 discarded
        do_arm(0, 0, 4);
        send(10, 1'b0);
        send(11, 1'b1);
        send(12, 1'b0);
        chk_status("imm 3", 1, 0, 3);
        send(13, 1'b0);
        chk_status("imm 4", 0, 1, 4);
        send(14, 1'b0);
        chk_status("imm extra", 0, 1, 4);
        for (int i = 0; i < 4; i++) rd(i, 10 + i);
        rd(4, 2004);

        // Rising threshold at 100
        do_arm(1, 100, 3);
        send(50, 1'b0);
        send(99, 1'b0);
        chk_status("thr below", 1, 0, 0);
        send(100, 1'b0);
        chk_status("thr trig", 1, 0, 1);
        send(200, 1'b0);
        send(30, 1'b0);
        chk_status("thr end", 0, 1, 3);
        send(150, 1'b0);
        chk_status("thr late", 0, 1, 3);
        rd(0, 100); rd(1, 200); rd(2, 30); rd(3, 13);

        // Signed threshold at -5: first sample after arm cannot trigger
        do_arm(1, -5, 2);
        send(20, 1'b0);
        send(-10, 1'b0);
        chk_status("sthr wait", 1, 0, 0);
        send(3, 1'b0);
        chk_status("sthr trig", 1, 0, 1);
        send(4, 1'b0);
        chk_status("sthr end", 0, 1, 2);
        rd(0, 3); rd(1, 4); rd(2, 30);

        // tlast trigger with tvalid toggling
        do_arm(2, 0, 2);
        for (int s = 1; s <= 6; s++) begin
            send(s, s == 3);
            tick();
            if (s == 3) chk_status("tl after last", 1, 0, 0);
            if (s == 4) chk_status("tl trig", 1, 0, 1);
            if (s == 5) chk_status("tl end", 0, 1, 2);
        end
        rd(0, 4); rd(1, 5); rd(2, 30);

        // Arm ignored mid-capture, then reset abort
        do_arm(0, 0, 8);
        send(50, 1'b0);
        send(51, 1'b0);
        do_arm(0, 0, 2);
        send(52, 1'b0);
        send(53, 1'b0);
        send(54, 1'b0);
        chk_status("abort pre", 1, 0, 5);
        resetn = 1'b0;
        tick();
        chk("abort tready", int'(s_axis_tready), 0);
        chk_status("abort rst", 0, 0, 0);
        resetn = 1'b1;
        tick();
        send(60, 1'b0);
        chk_status("abort idle", 0, 0, 0);
        do_arm(0, 0, 8);
        send(70, 1'b0);
        chk_status("rearm", 1, 0, 1);
        rd(0, 70); rd(4, 54); rd(5, 2005);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && rd_q.size() != 0; i++) tick();
        tick();
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads outstanding, want 0", rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
